regfile_port_sched: RTL and testbench

Scheduler for the CPU's single-port register file, whose one port either writes or reads each cycle. Accepts writeback writes and decode read requests in the same cycle, buffers writes in a small FIFO, and sequences the port between them. Forwards buffered and same-cycle writes to reads, so decode always sees architecturally current values. Sits between the decode/writeback stages and the register file.

---
 rtl/regfile_port_sched.sv | 117 +++++++++++
 tb/tb_regfile_port_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regfile_port_sched.sv
// regfile_port_sched: schedules a single-port register file between buffered writebacks and forwarded decode reads
module regfile_port_sched #(
  parameter int WB_DEPTH      = 2,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        rd_req_valid,
  output logic        rd_req_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rd_resp_valid,
  output logic [31:0] rd_resp_a,
  output logic [31:0] rd_resp_b,
  output logic        rf_rw,
  output logic [4:0]  rf_rd,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  output logic [31:0] rf_dataIn,
  input  logic [31:0] rf_out1,
  input  logic [31:0] rf_out2
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = $clog2(WB_DEPTH + 1);
  localparam int SW = $clog2(MAX_RD_STREAK + 1);
  localparam logic [CW-1:0] FULL = CW'(WB_DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(MAX_RD_STREAK);
  logic [4:0]    fifo_rd_q   [WB_DEPTH];
  logic [31:0]   fifo_data_q [WB_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          resp_valid_q, hit_a_q, hit_b_q;
  logic [31:0]   fwd_a_q, fwd_b_q;
  logic          acc, drain, read, hit_a, hit_b;
  logic [31:0]   fwd_a, fwd_b;
  assign wb_ready     = !rst && count_q != FULL;
  assign acc          = wb_valid && wb_ready && wb_rd != 5'd0;
  assign drain        = !rst && count_q != '0 && (count_q == FULL || streak_q == SMAX || !rd_req_valid);
  assign read         = !rst && rd_req_valid && !drain;
  assign rd_req_ready = read;
  assign rf_rw        = drain;
  assign rf_rd        = fifo_rd_q[head_q];
  assign rf_dataIn    = fifo_data_q[head_q];
  assign rf_rs1       = rs1;
  assign rf_rs2       = rs2;
  assign count_d      = count_q + CW'(acc) - CW'(drain);
  assign streak_d     = (read && count_q != '0) ? streak_q + SW'(1) : '0;
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (CW'(k) < count_q && fifo_rd_q[head_q + PW'(k)] == rs1) begin
        hit_a = 1'b1;
        fwd_a = fifo_data_q[head_q + PW'(k)];
      end
      if (CW'(k) < count_q && fifo_rd_q[head_q + PW'(k)] == rs2) begin
        hit_b = 1'b1;
        fwd_b = fifo_data_q[head_q + PW'(k)];
      end
    end
    if (acc && wb_rd == rs1) begin
      hit_a = 1'b1;
      fwd_a = wb_data;
    end
    if (acc && wb_rd == rs2) begin
      hit_b = 1'b1;
      fwd_b = wb_data;
    end
    if (rs1 == 5'd0) begin
      hit_a = 1'b1;
      fwd_a = '0;
    end
    if (rs2 == 5'd0) begin
      hit_b = 1'b1;
      fwd_b = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      streak_q     <= '0;
      resp_valid_q <= 1'b0;
      hit_a_q      <= 1'b0;
      hit_b_q      <= 1'b0;
      fwd_a_q      <= '0;
      fwd_b_q      <= '0;
    end else begin
      if (acc) begin
        fifo_rd_q[tail_q]   <= wb_rd;
        fifo_data_q[tail_q] <= wb_data;
        tail_q              <= tail_q + PW'(1);
      end
      if (drain) head_q <= head_q + PW'(1);
      count_q      <= count_d;
      streak_q     <= streak_d;
      resp_valid_q <= read;
      if (read) begin
        hit_a_q <= hit_a;
        hit_b_q <= hit_b;
        fwd_a_q <= fwd_a;
        fwd_b_q <= fwd_b;
      end
    end
  end
  assign rd_resp_valid = resp_valid_q;
  assign rd_resp_a     = resp_valid_q ? (hit_a_q ? fwd_a_q : rf_out1) : '0;
  assign rd_resp_b     = resp_valid_q ? (hit_b_q ? fwd_b_q : rf_out2) : '0;
endmodule

// File: tb/tb_regfile_port_sched.sv
// tb_regfile_port_sched: directed checks of port scheduling, forwarding and reset against a behavioural register file
module tb_regfile_port_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rd_req_valid, rd_req_ready;
  logic [4:0]  rs1, rs2;
  logic        rd_resp_valid;
  logic [31:0] rd_resp_a, rd_resp_b;
  logic        rf_rw;
  logic [4:0]  rf_rd, rf_rs1, rf_rs2;
  logic [31:0] rf_dataIn, rf_out1, rf_out2;
  logic [31:0] rf [32];
  logic [5:0]  rw_pat, rdy_pat;
  int          total = 0;
  int          bad = 0;
  regfile_port_sched #(.WB_DEPTH(2), .MAX_RD_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rs1(rs1), .rs2(rs2),
    .rd_resp_valid(rd_resp_valid), .rd_resp_a(rd_resp_a), .rd_resp_b(rd_resp_b),
    .rf_rw(rf_rw), .rf_rd(rf_rd), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_dataIn(rf_dataIn), .rf_out1(rf_out1), .rf_out2(rf_out2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      rf_out1 <= '0;
      rf_out2 <= '0;
    end else if (rf_rw) begin
      if (rf_rd != 5'd0) rf[rf_rd] <= rf_dataIn;
    end else begin
      rf_out1 <= rf[rf_rs1];
      rf_out2 <= rf[rf_rs2];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic rv, input logic [4:0] a, input logic [4:0] b);
    wb_valid = wv;
    wb_rd = wr;
    wb_data = wd;
    rd_req_valid = rv;
    rs1 = a;
    rs2 = b;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    drive(1, 5'd4, 32'h1, 1, 5'd1, 5'd2);
    tick();
    #1;
    check("rst_wb_ready", wb_ready, 0);
    check("rst_rd_ready", rd_req_ready, 0);
    check("rst_rf_rw", rf_rw, 0);
    check("rst_resp_valid", rd_resp_valid, 0);
    check("rst_resp_a", rd_resp_a, 0);
    tick();
    rst = 1'b0;
    drive(1, 5'd5, 32'h1234, 0, 5'd0, 5'd0);
    check("t1_wb_ready", wb_ready, 1);
    check("t1_idle_rw", rf_rw, 0);
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    check("t1_drain_rw", rf_rw, 1);
    check("t1_drain_rd", rf_rd, 5);
    check("t1_drain_data", rf_dataIn, 32'h1234);
    tick();
    drive(0, 5'd0, 32'h0, 1, 5'd5, 5'd0);
    check("t1_read_ready", rd_req_ready, 1);
    check("t1_read_rw", rf_rw, 0);
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    check("t1_resp_valid", rd_resp_valid, 1);
    check("t1_resp_a", rd_resp_a, 32'h1234);
    check("t1_resp_b", rd_resp_b, 0);
    tick();
    check("t1_pulse", rd_resp_valid, 0);
    drive(1, 5'd7, 32'hAAAA, 1, 5'd7, 5'd0);
    check("t2_read_ready", rd_req_ready, 1);
    check("t2_read_rw", rf_rw, 0);
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    check("t2_resp_a", rd_resp_a, 32'hAAAA);
    check("t2_resp_b", rd_resp_b, 0);
    check("t2_drain_rw", rf_rw, 1);
    check("t2_drain_rd", rf_rd, 7);
    tick();
    drive(1, 5'd3, 32'h1, 1, 5'd0, 5'd0);
    check("t3_read0_ready", rd_req_ready, 1);
    tick();
    drive(1, 5'd3, 32'h2, 1, 5'd3, 5'd7);
    check("t3_read1_ready", rd_req_ready, 1);
    check("t3_read1_rw", rf_rw, 0);
    tick();
    drive(1, 5'd9, 32'h99, 1, 5'd3, 5'd0);
    check("t3_samecyc_a", rd_resp_a, 2);
    check("t3_rf_b", rd_resp_b, 32'hAAAA);
    check("t5_full_wb_ready", wb_ready, 0);
    check("t5_full_rd_ready", rd_req_ready, 0);
    check("t5_full_rw", rf_rw, 1);
    check("t5_full_rd", rf_rd, 3);
    check("t5_full_data", rf_dataIn, 1);
    tick();
    drive(0, 5'd0, 32'h0, 1, 5'd3, 5'd9);
    check("t5_wb_ready_back", wb_ready, 1);
    check("t5_rd_ready_back", rd_req_ready, 1);
    check("t5_no_resp", rd_resp_valid, 0);
    rw_pat = {5'b0, rf_rw};
    rdy_pat = {5'b0, rd_req_ready};
    tick();
    check("t3_fifo_a", rd_resp_a, 2);
    check("t3_rejected_b", rd_resp_b, 0);
    for (int i = 0; i < 5; i++) begin
      rw_pat = {rw_pat[4:0], rf_rw};
      rdy_pat = {rdy_pat[4:0], rd_req_ready};
      if (i == 3) check("t4_streak_drain_data", rf_dataIn, 2);
      tick();
    end
    check("t4_rw_pattern", rw_pat, 6'b000010);
    check("t4_rdy_pattern", rdy_pat, 6'b111101);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    check("t4_rf_a", rd_resp_a, 2);
    tick();
    drive(1, 5'd0, 32'hFFFF, 0, 5'd0, 5'd0);
    check("t6_x0_wb_ready", wb_ready, 1);
    tick();
    drive(0, 5'd0, 32'h0, 1, 5'd0, 5'd5);
    check("t6_x0_no_drain", rf_rw, 0);
    check("t6_x0_read", rd_req_ready, 1);
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    check("t6_x0_a", rd_resp_a, 0);
    check("t6_x5_b", rd_resp_b, 32'h1234);
    tick();
    check("t6_x0_still_idle", rf_rw, 0);
    drive(1, 5'd10, 32'h5, 1, 5'd0, 5'd0);
    tick();
    drive(1, 5'd11, 32'h6, 1, 5'd0, 5'd0);
    check("t7_fill_read", rd_req_ready, 1);
    tick();
    rst = 1'b1;
    drive(0, 5'd0, 32'h0, 1, 5'd10, 5'd0);
    check("t7_rst_wb_ready", wb_ready, 0);
    check("t7_rst_rd_ready", rd_req_ready, 0);
    check("t7_rst_rw", rf_rw, 0);
    tick();
    rst = 1'b0;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    check("t7_post_no_drain", rf_rw, 0);
    check("t7_post_resp", rd_resp_valid, 0);
    check("t7_post_wb_ready", wb_ready, 1);
    tick();
    drive(0, 5'd0, 32'h0, 1, 5'd10, 5'd11);
    check("t7_post_no_drain2", rf_rw, 0);
    check("t7_post_read", rd_req_ready, 1);
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    check("t7_discard_a", rd_resp_a, 0);
    check("t7_discard_b", rd_resp_b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
